// File: rtl/phy_erase_mp.sv
// Multi-plane NAND block-erase sequencer.
// Per plane it drives 60h, three row-address bytes, then D1h (more planes follow)
// or D0h (last plane). After each confirm it waits out tWB, then polls the
// synchronised RB_n. An optional timeout bounds each ready wait.
//
// state  | meaning
// IDLE   | ready for a command
// CMD60  | erase setup command bus cycle (CLE)
// ADDR   | three row-address bus cycles (ALE), low byte first
// CMDD   | D1h/D0h confirm bus cycle (CLE)
// TWB    | tWB hold-off; RB_n is not looked at
// WAIT   | polling RB_n, with timeout count
// RESP   | result held until accepted
module phy_erase_mp #(
  parameter int LANES     = 4,
  parameter int T_CA      = 8,
  parameter int T_WB      = 16,
  parameter int MAX_PLANE = 4,
  parameter int TO_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [15:0]                   i_cmd_id,
  input  logic [$clog2(MAX_PLANE)-1:0]  i_plane_num,
  input  logic [24*MAX_PLANE-1:0]       i_row_addr,
  input  logic [TO_W-1:0]               i_timeout,
  output logic                          o_res_valid,
  input  logic                          i_res_ready,
  output logic [15:0]                   o_res_id,
  output logic [1:0]                    o_res_status,
  output logic                          o_ce_n,
  output logic                          o_we_n,
  output logic                          o_cle,
  output logic                          o_ale,
  output logic                          o_dq_tri_en,
  output logic [8*LANES-1:0]            o_dq,
  input  logic                          i_rb_n,
  output logic                          o_busy,
  output logic [1:0]                    o_status
);

  localparam int PW  = $clog2(MAX_PLANE);
  localparam int PHW = $clog2(T_CA);
  localparam int TWW = (T_WB > 1) ? $clog2(T_WB) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD60, S_ADDR, S_CMDD, S_TWB, S_WAIT, S_RESP
  } state_t;

  state_t                  state;
  logic [PHW-1:0]          phase;
  logic [1:0]              addr_idx;
  logic [PW-1:0]           plane;
  logic [PW-1:0]           plane_num;
  logic [15:0]             cmd_id;
  logic [24*MAX_PLANE-1:0] row_addr;
  logic [TO_W-1:0]         timeout;
  logic [TO_W-1:0]         wait_cnt;
  logic [TWW-1:0]          twb_cnt;
  logic                    rb_s1, rb_s2;
  logic [23:0]             cur_row;
  logic [7:0]              cur_byte;
  logic                    bus_st;
  logic                    phase_last;
  logic [TO_W-1:0]         wait_cnt_nxt;

  assign cur_row      = row_addr[24*int'(plane) +: 24];
  assign bus_st       = (state == S_CMD60) || (state == S_ADDR) || (state == S_CMDD);
  assign phase_last   = (phase == PHW'(T_CA - 1));
  assign wait_cnt_nxt = wait_cnt + TO_W'(1);

  // Byte presented on DQ for the current bus cycle.
  always_comb begin
    cur_byte = 8'h00;
    case (state)
      S_CMD60: cur_byte = 8'h60;
      S_ADDR: begin
        case (addr_idx)
          2'd0:    cur_byte = cur_row[7:0];
          2'd1:    cur_byte = cur_row[15:8];
          default: cur_byte = cur_row[23:16];
        endcase
      end
      S_CMDD:  cur_byte = (plane < plane_num) ? 8'hD1 : 8'hD0;
      default: cur_byte = 8'h00;
    endcase
  end

  // Two-flop synchroniser for the asynchronous ready/busy pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_s1 <= 1'b0;
      rb_s2 <= 1'b0;
    end else begin
      rb_s1 <= i_rb_n;
      rb_s2 <= rb_s1;
    end
  end

  // Sequencer FSM with command/response handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      phase        <= '0;
      addr_idx     <= '0;
      plane        <= '0;
      plane_num    <= '0;
      cmd_id       <= '0;
      row_addr     <= '0;
      timeout      <= '0;
      wait_cnt     <= '0;
      twb_cnt      <= '0;
      o_cmd_ready  <= 1'b0;
      o_res_valid  <= 1'b0;
      o_res_id     <= '0;
      o_res_status <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            cmd_id      <= i_cmd_id;
            plane_num   <= i_plane_num;
            row_addr    <= i_row_addr;
            timeout     <= i_timeout;
            plane       <= '0;
            phase       <= '0;
            addr_idx    <= '0;
            o_cmd_ready <= 1'b0;
            state       <= S_CMD60;
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end
        S_CMD60: begin
          if (phase_last) begin
            phase    <= '0;
            addr_idx <= '0;
            state    <= S_ADDR;
          end else begin
            phase <= phase + PHW'(1);
          end
        end
        S_ADDR: begin
          if (phase_last) begin
            phase <= '0;
            if (addr_idx == 2'd2) state <= S_CMDD;
            else addr_idx <= addr_idx + 2'd1;
          end else begin
            phase <= phase + PHW'(1);
          end
        end
        S_CMDD: begin
          if (phase_last) begin
            phase   <= '0;
            twb_cnt <= TWW'(T_WB - 1);
            state   <= S_TWB;
          end else begin
            phase <= phase + PHW'(1);
          end
        end
        S_TWB: begin
          if (twb_cnt == '0) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            twb_cnt <= twb_cnt - TWW'(1);
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt_nxt;
          // Ready wins over a timeout landing on the same clock.
          if (rb_s2) begin
            if (plane < plane_num) begin
              plane <= plane + PW'(1);
              phase <= '0;
              state <= S_CMD60;
            end else begin
              o_res_valid  <= 1'b1;
              o_res_id     <= cmd_id;
              o_res_status <= 2'b00;
              state        <= S_RESP;
            end
          end else if ((timeout != '0) && (wait_cnt_nxt == timeout)) begin
            o_res_valid  <= 1'b1;
            o_res_id     <= cmd_id;
            o_res_status <= 2'b01;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flash pins registered from current state, so every pin lags by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ce_n      <= 1'b1;
      o_we_n      <= 1'b1;
      o_cle       <= 1'b0;
      o_ale       <= 1'b0;
      o_dq_tri_en <= 1'b1;
      o_dq        <= '0;
      o_busy      <= 1'b0;
      o_status    <= 2'b00;
    end else begin
      o_ce_n      <= (state == S_IDLE) || (state == S_RESP);
      o_we_n      <= !(bus_st && (phase < PHW'(T_CA / 2)));
      o_cle       <= (state == S_CMD60) || (state == S_CMDD);
      o_ale       <= (state == S_ADDR);
      o_dq_tri_en <= !bus_st;
      o_dq        <= bus_st ? {LANES{cur_byte}} : '0;
      o_busy      <= bus_st;
      case (state)
        S_IDLE:                   o_status <= 2'b00;
        S_CMD60, S_ADDR, S_CMDD:  o_status <= 2'b01;
        S_TWB, S_WAIT:            o_status <= 2'b10;
        default:                  o_status <= 2'b11;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_erase_mp.sv
// Directed bench for phy_erase_mp with default parameters.
module tb_phy_erase_mp;

  localparam int LANES = 4;

  logic        clk, rst;
  logic        i_cmd_valid, o_cmd_ready;
  logic [15:0] i_cmd_id;
  logic [1:0]  i_plane_num;
  logic [95:0] i_row_addr;
  logic [23:0] i_timeout;
  logic        o_res_valid, i_res_ready;
  logic [15:0] o_res_id;
  logic [1:0]  o_res_status;
  logic        o_ce_n, o_we_n, o_cle, o_ale, o_dq_tri_en;
  logic [31:0] o_dq;
  logic        i_rb_n, o_busy;
  logic [1:0]  o_status;

  int checks = 0;
  int failures = 0;

  phy_erase_mp dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_id(i_cmd_id),
    .i_plane_num(i_plane_num), .i_row_addr(i_row_addr), .i_timeout(i_timeout),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_id(o_res_id),
    .o_res_status(o_res_status), .o_ce_n(o_ce_n), .o_we_n(o_we_n), .o_cle(o_cle),
    .o_ale(o_ale), .o_dq_tri_en(o_dq_tri_en), .o_dq(o_dq), .i_rb_n(i_rb_n),
    .o_busy(o_busy), .o_status(o_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        cle;
    logic        ale;
    logic [31:0] dq;
  } rise_t;

  rise_t rises[$];
  logic  prev_we = 1'b1;
  logic  ce_err = 1'b0;

  // Record CLE/ALE/DQ at each WE_n rising edge; flag CE_n high mid-operation.
  always @(negedge clk) begin
    if (!rst) begin
      if (!prev_we && o_we_n) rises.push_back('{cle: o_cle, ale: o_ale, dq: o_dq});
      if ((o_status == 2'b01 || o_status == 2'b10) && o_ce_n) ce_err = 1'b1;
    end
    prev_we = o_we_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] id, input logic [1:0] pn,
                       input logic [95:0] rows, input logic [23:0] to);
    int k;
    k = 0;
    @(negedge clk);
    while (!o_cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_before_issue", o_cmd_ready, 1'b1);
    i_cmd_id = id; i_plane_num = pn; i_row_addr = rows; i_timeout = to;
    i_cmd_valid = 1'b1;
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (o_res_valid) break;
    end
    check("resp_within_bound", o_res_valid, 1'b1);
  endtask

  task automatic wait_rises(input int target, input int max);
    int k;
    k = 0;
    while (rises.size() < target && k < max) begin
      @(negedge clk);
      k++;
    end
    check("rises_reached", rises.size() >= target, 1'b1);
  endtask

  task automatic ack();
    @(negedge clk);
    i_res_ready = 1'b1;
    @(posedge clk);
    #1 i_res_ready = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cmd_ready"}, o_cmd_ready, 1'b0);
    check({tag, "_res_valid"}, o_res_valid, 1'b0);
    check({tag, "_res_id"}, o_res_id, 16'h0);
    check({tag, "_res_status"}, o_res_status, 2'b00);
    check({tag, "_ce_n"}, o_ce_n, 1'b1);
    check({tag, "_we_n"}, o_we_n, 1'b1);
    check({tag, "_cle_ale"}, {o_cle, o_ale}, 2'b00);
    check({tag, "_tri"}, o_dq_tri_en, 1'b1);
    check({tag, "_dq"}, o_dq, 32'h0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_status"}, o_status, 2'b00);
  endtask

  task automatic check_rises(input string tag, input int cnt,
                             input logic [7:0] b [10], input logic [9:0] cle_m,
                             input logic [9:0] ale_m);
    check({tag, "_rise_count"}, rises.size(), cnt);
    for (int i = 0; i < cnt && i < rises.size(); i++) begin
      check({tag, "_dq"}, rises[i].dq, {LANES{b[i]}});
      check({tag, "_cle"}, rises[i].cle, cle_m[i]);
      check({tag, "_ale"}, rises[i].ale, ale_m[i]);
    end
  endtask

  initial begin
    logic [7:0] eb [10];
    int  n;
    logic stuck;

    rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_id = '0; i_plane_num = '0;
    i_row_addr = '0; i_timeout = '0; i_res_ready = 1'b0; i_rb_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", o_cmd_ready, 1'b1);

    // Single plane, row 0x012345, RB_n low 100 clocks.
    rises.delete(); ce_err = 1'b0; i_rb_n = 1'b0;
    issue(16'hA5A5, 2'd0, {72'h0, 24'h012345}, 24'd0);
    repeat (100) @(posedge clk);
    #1 i_rb_n = 1'b1;
    wait_resp(200, n);
    check("t1_status", o_res_status, 2'b00);
    check("t1_id", o_res_id, 16'hA5A5);
    eb[0] = 8'h60; eb[1] = 8'h45; eb[2] = 8'h23; eb[3] = 8'h01; eb[4] = 8'hD0;
    check_rises("t1", 5, eb, 10'b0000010001, 10'b0000001110);
    check("t1_ce_hold", ce_err, 1'b0);
    @(negedge clk);
    check("t1_resp_pins", {o_status, o_ce_n, o_busy, o_dq_tri_en}, {2'b11, 1'b1, 1'b0, 1'b1});
    ack();
    @(negedge clk);
    check("t1_after_ack", {o_res_valid, o_cmd_ready}, 2'b01);

    // Two planes, rows 0x000100 / 0x000180.
    rises.delete(); ce_err = 1'b0; i_rb_n = 1'b0;
    issue(16'h0002, 2'd1, {48'h0, 24'h000180, 24'h000100}, 24'd0);
    wait_rises(5, 200);
    repeat (30) @(posedge clk);
    #1 i_rb_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 i_rb_n = 1'b0;
    wait_rises(10, 300);
    repeat (30) @(posedge clk);
    #1 i_rb_n = 1'b1;
    wait_resp(100, n);
    check("t2_status", o_res_status, 2'b00);
    check("t2_id", o_res_id, 16'h0002);
    eb[0] = 8'h60; eb[1] = 8'h00; eb[2] = 8'h01; eb[3] = 8'h00; eb[4] = 8'hD1;
    eb[5] = 8'h60; eb[6] = 8'h80; eb[7] = 8'h01; eb[8] = 8'h00; eb[9] = 8'hD0;
    check_rises("t2", 10, eb, 10'b1000110001, 10'b0111001110);
    check("t2_ce_hold", ce_err, 1'b0);
    ack();

    // Timeout 50 with RB_n stuck low: 40 bus + 16 tWB + 50 wait clocks.
    rises.delete(); i_rb_n = 1'b0;
    issue(16'h0003, 2'd0, {72'h0, 24'hABCDEF}, 24'd50);
    wait_resp(300, n);
    check("t3_latency", n, 106);
    check("t3_status", o_res_status, 2'b01);
    check("t3_id", o_res_id, 16'h0003);
    repeat (2) @(negedge clk);
    check("t3_ce_n_high", o_ce_n, 1'b1);
    // Response back-pressure with a competing command.
    i_cmd_id = 16'h7777; i_plane_num = 2'd0; i_timeout = 24'd0; i_cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_hold", {o_res_valid, o_res_id, o_res_status, o_cmd_ready},
            {1'b1, 16'h0003, 2'b01, 1'b0});
    end
    i_cmd_valid = 1'b0;
    i_res_ready = 1'b1;
    @(posedge clk);
    #1 i_res_ready = 1'b0;
    @(negedge clk);
    check("t3_after_ack", {o_res_valid, o_cmd_ready}, 2'b01);
    repeat (3) @(negedge clk);
    check("t3_no_new_cmd", o_status, 2'b00);
    check("t3_no_more_we", rises.size(), 5);

    // RB_n high on the same clock as the timeout hit: pass wins.
    i_rb_n = 1'b0;
    issue(16'h0004, 2'd0, {72'h0, 24'h000010}, 24'd20);
    repeat (73) @(posedge clk);
    @(negedge clk) i_rb_n = 1'b1;
    wait_resp(20, n);
    check("t4a_latency", n, 3);
    check("t4a_status", o_res_status, 2'b00);
    ack();

    // RB_n one clock too late: timeout wins.
    i_rb_n = 1'b0;
    issue(16'h0014, 2'd0, {72'h0, 24'h000020}, 24'd20);
    repeat (74) @(posedge clk);
    @(negedge clk) i_rb_n = 1'b1;
    wait_resp(20, n);
    check("t4b_latency", n, 2);
    check("t4b_status", o_res_status, 2'b01);
    ack();

    // RB_n pulse during tWB is ignored.
    rises.delete(); i_rb_n = 1'b0;
    issue(16'h0005, 2'd0, {72'h0, 24'h000555}, 24'd0);
    wait_rises(5, 200);
    repeat (3) @(posedge clk);
    #1 i_rb_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 i_rb_n = 1'b0;
    stuck = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_res_valid) stuck = 1'b1;
    end
    check("t5_twb_pulse_ignored", stuck, 1'b0);
    check("t5_still_waiting", o_status, 2'b10);
    i_rb_n = 1'b1;
    wait_resp(20, n);
    check("t5_status", o_res_status, 2'b00);
    check("t5_id", o_res_id, 16'h0005);
    ack();

    // Reset during the second address byte, then a clean command.
    rises.delete(); i_rb_n = 1'b0;
    issue(16'h0006, 2'd0, {72'h0, 24'h0FFFFF}, 24'd0);
    wait_rises(2, 100);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outs("midrst");
    @(negedge clk) rst = 1'b0;
    rises.delete();
    issue(16'h0007, 2'd0, {72'h0, 24'h012345}, 24'd0);
    wait_rises(5, 200);
    repeat (30) @(posedge clk);
    #1 i_rb_n = 1'b1;
    wait_resp(100, n);
    check("t6_status", o_res_status, 2'b00);
    check("t6_id", o_res_id, 16'h0007);
    eb[0] = 8'h60; eb[1] = 8'h45; eb[2] = 8'h23; eb[3] = 8'h01; eb[4] = 8'hD0;
    check_rises("t6", 5, eb, 10'b0000010001, 10'b0000001110);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phy_erase_mp.md
PHY_ERASE_MP -- requirements
Module: phy_erase_mp

Interface
REQ-001 SHALL have parameter LANES, default 4, number of replicated 8-bit DQ lanes.
REQ-002 SHALL have parameter T_CA, default 8, clocks per CLE/ALE bus cycle (even, >=4).
REQ-003 SHALL have parameter T_WB, default 16, clocks from last WE_n rise to first RB_n sample.
REQ-004 SHALL have parameter MAX_PLANE, default 4, maximum planes per erase (power of 2, >=2).
REQ-005 SHALL have parameter TO_W, default 24, timeout counter width.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset (asynchronous, active-high).
REQ-007 SHALL have ports: i_cmd_valid in 1; o_cmd_ready out 1; i_cmd_id in 16; i_plane_num in clog2(MAX_PLANE), plane count minus 1; i_row_addr in 24*MAX_PLANE, plane p row at [24p+23:24p]; i_timeout in TO_W, max WAIT clocks, 0 = none.
REQ-008 SHALL have ports: o_res_valid out 1; i_res_ready in 1; o_res_id out 16; o_res_status out 2 (00 pass, 01 timeout).
REQ-009 SHALL have ports: o_ce_n, o_we_n, o_cle, o_ale, o_dq_tri_en (1 = input) out 1 each; o_dq out 8*LANES; i_rb_n in 1 asynchronous; o_busy out 1 (DQ bus in use); o_status out 2.

Function
REQ-010 SHALL implement states IDLE, CMD60, ADDR, CMDD, TWB, WAIT, RESP.
REQ-011 SHALL assert o_cmd_ready only in IDLE and capture id, plane_num, row_addr, timeout on valid&ready; IDLE->CMD60 on that edge.
REQ-012 SHALL ignore i_cmd_valid outside IDLE.
REQ-013 SHALL hold each bus cycle (CMD60, each ADDR byte, CMDD) for exactly T_CA clocks via a phase counter 0..T_CA-1.
REQ-014 SHALL drive o_we_n low for phases 0..T_CA/2-1 and high otherwise in bus states, giving one WE_n rising edge per bus cycle; o_we_n high elsewhere.
REQ-015 SHALL send per plane p: 60h; row bytes [7:0], [15:8], [23:16]; then D1h if p<plane_num, else D0h.
REQ-016 SHALL assert o_cle during CMD60/CMDD and o_ale during ADDR only, never both.
REQ-017 SHALL drive o_dq as the current byte replicated LANES times, o_dq_tri_en=0 in bus states; o_dq=0 and o_dq_tri_en=1 elsewhere.
REQ-018 SHALL, after each CMDD, spend T_WB clocks in TWB with RB_n ignored, then enter WAIT.
REQ-019 SHALL synchronise i_rb_n through two flops; WAIT exits on synchronised high: to CMD60 with p+1 if p<plane_num, else to RESP with status 00.
REQ-020 SHALL count WAIT clocks from 0 per WAIT entry; when count equals a nonzero captured timeout, go to RESP with status 01, skipping remaining planes.
REQ-021 SHALL, if RB_n high and timeout hit on the same clock, report pass (00).
REQ-022 SHALL hold o_res_valid, o_res_id, o_res_status stable in RESP until i_res_ready, then go to IDLE; i_res_ready outside RESP ignored.
REQ-023 SHALL drive o_ce_n low from CMD60 of plane 0 through final WAIT, high in IDLE and RESP.
REQ-024 SHALL set o_busy=1 in CMD60/ADDR/CMDD, else 0.
REQ-025 SHALL set o_status 00 IDLE, 01 CMD60/ADDR/CMDD, 10 TWB/WAIT, 11 RESP.
REQ-026 SHALL register all outputs; bus outputs lag state entry by at most one clock, uniformly for all pins.

Reset
REQ-027 SHALL on rst force IDLE and: o_cmd_ready 0 (1 one clock after release), o_res_valid 0, o_res_id 0, o_res_status 0, o_ce_n 1, o_we_n 1, o_cle 0, o_ale 0, o_dq_tri_en 1, o_dq 0, o_busy 0, o_status 00, counters 0.
REQ-028 SHALL abort any operation on mid-operation reset without completing bus cycles or issuing a response.

Verification
REQ-029 Single plane, row 0x012345, T_CA=8 -> DQ 60,45,23,01,D0 on 5 WE_n rises, CLE on 60/D0, ALE on address bytes; RB_n low 100 clk then high -> one response, status 00, id echoed.
REQ-030 plane_num=1, rows 0x000100/0x000180 -> 60,00,01,00,D1, TWB/WAIT, 60,80,01,00,D0; 10 WE_n rises total; CE_n low throughout.
REQ-031 i_timeout=50, RB_n stuck low -> status 01 exactly 50 clk after WAIT entry, CE_n high, no further WE_n pulses.
REQ-032 i_res_ready low 20 clk -> o_res_valid/id/status stable, o_cmd_ready 0, concurrent i_cmd_valid ignored; accept one clock after ready.
REQ-033 RB_n pulse high during TWB -> ignored; WAIT still requires later RB_n high.
REQ-034 rst during second ADDR byte -> all outputs at REQ-027 values immediately; next command runs normally.
